// File: rtl/cla4_initiator.sv
// -----------------------------------------------------------------------------
// cla4_initiator
//
// Sequences one operation at a time through an external clocked 4-bit adder.
// A request is accepted in IDLE. The operands are latched onto add_a/add_b and
// held there. add_start is raised for WAIT_CYCLES cycles. The adder result is
// captured and then presented to the host with a valid/ready handshake. A
// guard gap follows before the next request can be accepted.
//
// Parameters
//   WAIT_CYCLES  cycles add_start stays high per operation (10..31)
//   GAP_CYCLES   cycles spent in GAP after a response handshake (2..7)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake; req_a, req_b operands
//   rsp_valid/rsp_ready     response handshake; rsp_sum, rsp_cout result
//   busy                    high whenever the FSM is not in IDLE
//   add_start               start level to the adder (adder acts on its rise)
//   add_a, add_b            operands to the adder
//   add_sum, add_cout       adder results
//   chk_err                 sticky result-mismatch flag
//
// Optional feature: define CLA4_INIT_CHECK_EN to enable a result checker.
// The checker compares the adder result against add_a+add_b in CAPTURE and
// sets chk_err on a mismatch. Without the macro, chk_err is tied to 0 and no
// checker logic exists.
// -----------------------------------------------------------------------------
module cla4_initiator #(
  parameter int WAIT_CYCLES = 12,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_sum,
  output logic       rsp_cout,
  output logic       busy,
  output logic       add_start,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [3:0] add_sum,
  input  logic       add_cout,
  output logic       chk_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    CAPTURE = 3'd2,
    RESP    = 3'd3,
    GAP     = 3'd4
  } state_t;

  // RUN holds one setup cycle (operands settle, add_start still low) followed
  // by WAIT_CYCLES cycles with add_start high, so the counter runs 0..WAIT_CYCLES.
  localparam logic [4:0] RUN_TERM = 5'(WAIT_CYCLES);
  localparam logic [4:0] GAP_TERM = 5'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] add_a_q, add_a_d;
  logic [3:0] add_b_q, add_b_d;
  logic [3:0] rsp_sum_q, rsp_sum_d;
  logic       rsp_cout_q, rsp_cout_d;
  logic       add_start_q, add_start_d;
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       busy_q, busy_d;

  // The counter stops at its terminal value instead of wrapping.
  function automatic logic [4:0] sat_inc(input logic [4:0] c, input logic [4:0] term);
    return (c >= term) ? c : c + 5'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;

    unique case (state_q)
      IDLE: begin
        // req_ready_q is still 0 on the first cycle after reset, so no
        // acceptance can happen before req_ready is visible to the host.
        if (req_valid && req_ready_q) begin
          state_d = RUN;
          cnt_d   = '0;
          add_a_d = req_a;
          add_b_d = req_b;
        end
      end
      RUN: begin
        if (cnt_q == RUN_TERM) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q, RUN_TERM);
        end
      end
      CAPTURE: begin
        rsp_sum_d  = add_sum;
        rsp_cout_d = add_cout;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_TERM) begin
          state_d = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q, GAP_TERM);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    // add_start skips the first RUN cycle, so the operands are already
    // stable when the adder sees the rising edge.
    add_start_d = (state_q == RUN) && (state_d == RUN);
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      add_start_q <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      add_start_q <= add_start_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = busy_q;
  assign add_start = add_start_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;

`ifdef CLA4_INIT_CHECK_EN
  logic       chk_err_q, chk_err_d;
  logic [4:0] chk_ref;

  // Compare against the value that is loaded into rsp_sum/rsp_cout at the
  // end of CAPTURE. Once set, the flag stays set until reset.
  always_comb begin
    chk_ref   = {1'b0, add_a_q} + {1'b0, add_b_q};
    chk_err_d = chk_err_q;
    if ((state_q == CAPTURE) && ({add_cout, add_sum} != chk_ref)) begin
      chk_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_q <= 1'b0;
    end else begin
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_cla4_initiator.sv
// -----------------------------------------------------------------------------
// tb_cla4_initiator
//
// Self-checking bench for cla4_initiator, built with the default parameters.
// The bench contains a behavioural clocked 4-bit adder. This adder can be made
// to return a wrong sum so the optional checker can be exercised. Each
// operation pushes its expected {cout,sum} onto a scoreboard queue. The entry
// is popped and compared when rsp_valid appears.
// -----------------------------------------------------------------------------
module tb_cla4_initiator;

  localparam int W = 12;
  localparam int G = 2;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       req_valid = 1'b0;
  logic       rsp_ready = 1'b0;
  logic [3:0] req_a     = 4'h0;
  logic [3:0] req_b     = 4'h0;
  logic       req_ready, rsp_valid, rsp_cout, busy, add_start, add_cout, chk_err;
  logic [3:0] rsp_sum, add_a, add_b, add_sum;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [4:0] exp_q[$];
  logic       exp_chk  = 1'b0;
  logic       corrupt  = 1'b0;

  always #5 clk = ~clk;

  cla4_initiator #(
    .WAIT_CYCLES(W),
    .GAP_CYCLES (G)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum  (rsp_sum),
    .rsp_cout (rsp_cout),
    .busy     (busy),
    .add_start(add_start),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .chk_err  (chk_err)
  );

  // Clocked adder model: samples its operands on the rising edge of add_start.
  logic       start_prev = 1'b0;
  logic [3:0] mdl_sum    = 4'h0;
  logic       mdl_cout   = 1'b0;

  always @(posedge clk) begin
    start_prev <= add_start;
    if (add_start && !start_prev) begin
      {mdl_cout, mdl_sum} <= {1'b0, add_a} + {1'b0, add_b};
    end
  end

  assign add_sum  = corrupt ? ~mdl_sum : mdl_sum;
  assign add_cout = mdl_cout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_add_start"}, add_start, 0);
    check({tag, "_add_a"},     add_a,     0);
    check({tag, "_add_b"},     add_b,     0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_sum"},   rsp_sum,   0);
    check({tag, "_rsp_cout"},  rsp_cout,  0);
    check({tag, "_chk_err"},   chk_err,   0);
  endtask

  // add_start must stay low for at least G+2 cycles between operations.
  int lo_run  = 0;
  bit seen_op = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      lo_run  <= 0;
      seen_op <= 1'b0;
    end else if (add_start) begin
      if (seen_op && lo_run > 0) check("start_low_gap", (lo_run >= G + 2) ? 1 : 0, 1);
      lo_run  <= 0;
      seen_op <= 1'b1;
    end else begin
      lo_run <= lo_run + 1;
    end
  end

  // Called and returns at a falling edge. wait_n counts the edges that pass,
  // after entry, before req_ready is seen.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int bp,
                        input bit keep, input logic [3:0] na, input logic [3:0] nb,
                        output int wait_n);
    int         lat;
    int         starts;
    bit         rdy_seen;
    logic [4:0] e;
    logic [4:0] got;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    rsp_ready = (bp == 0);
    e = {1'b0, a} + {1'b0, b};
    if (corrupt) e[3:0] = ~e[3:0];
    exp_q.push_back(e);
    wait_n = 0;
    while (!req_ready && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    check("req_ready", req_ready, 1);
    @(posedge clk);                 // acceptance edge (edge 0)
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    req_valid = keep;
    req_a     = 4'($urandom);      // must be ignored from here on
    req_b     = 4'($urandom);
    lat      = 0;
    starts   = add_start ? 1 : 0;
    rdy_seen = req_ready;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (add_start) starts++;
      if (req_ready) rdy_seen = 1'b1;
    end
    check("rsp_latency", lat, W + 2);
    check("start_len", starts, W);
    check("ready_during_op", rdy_seen, 0);
    check("add_a_hold", add_a, a);
    check("add_b_hold", add_b, b);
    got = {rsp_cout, rsp_sum};
    check("sb_size", exp_q.size(), 1);
    if (exp_q.size() > 0) check("rsp_data", got, exp_q.pop_front());
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_hold", {rsp_cout, rsp_sum}, got);
      check("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);                 // handshake edge
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done", rsp_valid, 0);
    check("rsp_keep", {rsp_cout, rsp_sum}, got);
    check("chk_err", chk_err, exp_chk);
    if (keep) begin
      req_a = na;
      req_b = nb;
    end
    $display("op a=%h b=%h bp=%0d -> sum=%h cout=%b lat=%0d", a, b, bp, got[3:0], got[4], lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wn;
    int cnt;
    #12;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);

    run_op(4'h9, 4'h8, 0, 1'b0, 4'h0, 4'h0, wn);   // 17 -> sum 1, cout 1
    run_op(4'hF, 4'hF, 0, 1'b0, 4'h0, 4'h0, wn);   // 30 -> sum E, cout 1
    run_op(4'h0, 4'h0, 0, 1'b0, 4'h0, 4'h0, wn);
    run_op(4'h5, 4'h6, 5, 1'b0, 4'h0, 4'h0, wn);   // backpressure
    for (int i = 0; i < 4; i++) begin
      run_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'b0, 4'h0, 4'h0, wn);
    end

    // Back-to-back with req_valid held high.
    run_op(4'h3, 4'h4, 0, 1'b1, 4'hC, 4'h7, wn);
    run_op(4'hC, 4'h7, 0, 1'b0, 4'h0, 4'h0, wn);
    check("b2b_gap", wn + 1, G + 1);

    // Reset at RUN cycle 5.
    req_a     = 4'hA;
    req_b     = 4'h3;
    req_valid = 1'b1;
    cnt = 0;
    while (!req_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("mid_req_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_run_start", add_start, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("no_rsp_after_rst", cnt, 0);
    run_op(4'h7, 4'h9, 0, 1'b0, 4'h0, 4'h0, wn);

    // Wrong adder result: chk_err is set only when the checker is built in.
    corrupt = 1'b1;
`ifdef CLA4_INIT_CHECK_EN
    exp_chk = 1'b1;
`endif
    run_op(4'h2, 4'h3, 0, 1'b0, 4'h0, 4'h0, wn);
    corrupt = 1'b0;
    run_op(4'h1, 4'h1, 2, 1'b0, 4'h0, 4'h0, wn);    // flag stays sticky
    #2 rst_n = 1'b0;
    exp_chk = 1'b0;
    #1 check("chk_err_rst", chk_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(4'h8, 4'h8, 0, 1'b0, 4'h0, 4'h0, wn);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
